// File: rtl/surf_idctrl_pkg.sv
// Shared definitions for the SURF ID/control register target and its initiators.
package surf_idctrl_pkg;

    // ID/control register map (byte addresses)
    localparam logic [10:0] IDCTRL_DEVICE_ADDR   = 11'h000;
    localparam logic [10:0] IDCTRL_VERSION_ADDR  = 11'h004;
    localparam logic [10:0] IDCTRL_DNA_ADDR      = 11'h008;
    localparam logic [10:0] IDCTRL_CTRLSTAT_ADDR = 11'h00C;
    localparam logic [10:0] IDCTRL_HSKCOUNT_ADDR = 11'h010;

    // Writing this bit of the DNA register pulses the DNA port load
    localparam int DNA_READ_BIT = 31;

    typedef enum logic [2:0] {
        DNA_IDLE,
        DNA_LOAD,
        DNA_LGAP,
        DNA_READ,
        DNA_RGAP,
        DNA_DONE,
        DNA_ERROR
    } dna_state_t;

    typedef enum logic [1:0] {
        WBM_IDLE,
        WBM_BUSY,
        WBM_WAIT
    } wbm_state_t;

endpackage

// File: rtl/wb_single_master.sv
// Single wishbone access engine: raises cyc on go_i, waits for a response,
// reissues after rty (with an idle gap), and flags done/fail with timeout.
module wb_single_master
    import surf_idctrl_pkg::*;
#(
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int MAX_RETRY      = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        go_i,
    input  logic        ack_i,
    input  logic        err_i,
    input  logic        rty_i,
    input  logic [31:0] dat_i,
    output logic        cyc_o,
    output logic        done_o,
    output logic        fail_o,
    output logic [31:0] rdata_o
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RW = $clog2(MAX_RETRY + 2);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    wbm_state_t    state_q, state_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [RW-1:0] rty_q, rty_d;
    logic [GW-1:0] gap_q, gap_d;

    // Access engine state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= WBM_IDLE;
            tmo_q   <= '0;
            rty_q   <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            rty_q   <= rty_d;
            gap_q   <= gap_d;
        end
    end

    // Response handling: err beats ack beats rty; timeout only when nothing came back
    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        rty_d   = rty_q;
        gap_d   = gap_q;
        done_o  = 1'b0;
        fail_o  = 1'b0;
        unique case (state_q)
            WBM_IDLE: begin
                if (go_i) begin
                    state_d = WBM_BUSY;
                    tmo_d   = '0;
                    rty_d   = '0;
                end
            end
            WBM_BUSY: begin
                if (err_i) begin
                    fail_o  = 1'b1;
                    state_d = WBM_IDLE;
                end else if (ack_i) begin
                    done_o  = 1'b1;
                    state_d = WBM_IDLE;
                end else if (rty_i) begin
                    if (rty_q == RW'(MAX_RETRY)) begin
                        fail_o  = 1'b1;
                        state_d = WBM_IDLE;
                    end else begin
                        rty_d   = rty_q + RW'(1);
                        gap_d   = '0;
                        state_d = WBM_WAIT;
                    end
                end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    fail_o  = 1'b1;
                    state_d = WBM_IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            WBM_WAIT: begin
                if (gap_q == GW'(GAP_CYCLES - 1)) begin
                    state_d = WBM_BUSY;
                    tmo_d   = '0;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: state_d = WBM_IDLE;
        endcase
    end

    assign cyc_o   = (state_q == WBM_BUSY);
    assign rdata_o = dat_i;

endmodule

// File: rtl/surf_dna_reader.sv
// Reads the 96-bit device DNA through the ID/control wishbone target:
// one load write, then one single-bit read per DNA bit, gap after each ack.
module surf_dna_reader
    import surf_idctrl_pkg::*;
#(
    parameter int                     DNA_BITS       = 96,
    parameter int                     WB_ADR_BITS    = 11,
    parameter logic [WB_ADR_BITS-1:0] DNA_ADDR       = IDCTRL_DNA_ADDR,
    parameter int                     GAP_CYCLES     = 2,
    parameter int                     TIMEOUT_CYCLES = 255,
    parameter int                     MAX_RETRY      = 3
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    input  logic                   start_i,
    output logic                   busy_o,
    output logic                   valid_o,
    output logic                   error_o,
    output logic [DNA_BITS-1:0]    dna_o,
    output logic                   wb_cyc_o,
    output logic                   wb_stb_o,
    output logic                   wb_we_o,
    output logic [WB_ADR_BITS-1:0] wb_adr_o,
    output logic [31:0]            wb_dat_o,
    output logic [3:0]             wb_sel_o,
    input  logic                   wb_ack_i,
    input  logic                   wb_err_i,
    input  logic                   wb_rty_i,
    input  logic [31:0]            wb_dat_i
);

    localparam int          CW        = $clog2(DNA_BITS + 1);
    localparam int          GW        = $clog2(GAP_CYCLES + 1);
    localparam logic [31:0] LOAD_WORD = 32'h1 << DNA_READ_BIT;

    dna_state_t          state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [GW-1:0]       gap_q, gap_d;
    logic                pend_q, pend_d;
    logic [DNA_BITS-1:0] dna_q, dna_d;

    logic        go;
    logic        m_cyc, m_done, m_fail;
    logic [31:0] m_rdata;
    logic        unused_rdata;

    wb_single_master #(
        .GAP_CYCLES    (GAP_CYCLES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .MAX_RETRY     (MAX_RETRY)
    ) u_master (
        .clk_i  (wb_clk_i),
        .rst_i  (wb_rst_i),
        .go_i   (go),
        .ack_i  (wb_ack_i),
        .err_i  (wb_err_i),
        .rty_i  (wb_rty_i),
        .dat_i  (wb_dat_i),
        .cyc_o  (m_cyc),
        .done_o (m_done),
        .fail_o (m_fail),
        .rdata_o(m_rdata)
    );

    // Only bit 0 of the read data carries DNA
    assign unused_rdata = ^m_rdata[31:1];

    // Sequencer state, bit counter, gap counter and DNA shadow
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= DNA_IDLE;
            cnt_q   <= '0;
            gap_q   <= '0;
            pend_q  <= 1'b0;
            dna_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            pend_q  <= pend_d;
            dna_q   <= dna_d;
        end
    end

    // Sequencing: the next read is launched in the last gap cycle so cyc
    // rises exactly GAP_CYCLES after it dropped
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        pend_d  = 1'b0;
        dna_d   = dna_q;
        go      = 1'b0;
        unique case (state_q)
            DNA_IDLE, DNA_DONE, DNA_ERROR: begin
                if (start_i) begin
                    state_d = DNA_LOAD;
                    cnt_d   = '0;
                    pend_d  = 1'b1;
                end
            end
            DNA_LOAD: begin
                go = pend_q;
                if (m_fail) begin
                    state_d = DNA_ERROR;
                end else if (m_done) begin
                    state_d = DNA_LGAP;
                    gap_d   = '0;
                end
            end
            DNA_READ: begin
                if (m_fail) begin
                    state_d = DNA_ERROR;
                end else if (m_done) begin
                    dna_d[cnt_q] = m_rdata[0];
                    cnt_d        = cnt_q + CW'(1);
                    gap_d        = '0;
                    state_d      = DNA_RGAP;
                end
            end
            DNA_LGAP, DNA_RGAP: begin
                if (gap_q == GW'(GAP_CYCLES - 1)) begin
                    if (state_q == DNA_LGAP || cnt_q < CW'(DNA_BITS)) begin
                        go      = 1'b1;
                        state_d = DNA_READ;
                    end else begin
                        state_d = DNA_DONE;
                    end
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: state_d = DNA_IDLE;
        endcase
    end

    assign busy_o   = (state_q == DNA_LOAD) || (state_q == DNA_LGAP) ||
                      (state_q == DNA_READ) || (state_q == DNA_RGAP);
    assign valid_o  = (state_q == DNA_DONE);
    assign error_o  = (state_q == DNA_ERROR);
    assign dna_o    = dna_q;

    assign wb_cyc_o = m_cyc;
    assign wb_stb_o = m_cyc;
    assign wb_we_o  = m_cyc && (state_q == DNA_LOAD);
    assign wb_adr_o = DNA_ADDR;
    assign wb_dat_o = wb_we_o ? LOAD_WORD : 32'h0;
    assign wb_sel_o = !m_cyc ? 4'b0000 : (wb_we_o ? 4'b1000 : 4'b1111);

endmodule

// File: tb/tb_surf_dna_reader.sv
// Self-checking bench for surf_dna_reader with a behavioural ID/control target.
module tb_surf_dna_reader;

    localparam logic [95:0] PAT  = 96'hA5A5_0F0F_1234_5678_9ABC_DEF0;
    localparam logic [95:0] PAT2 = 96'h3C3C_F00F_8001_7FFE_0123_4567;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic        busy_o, valid_o, error_o;
    logic [95:0] dna_o;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [10:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_ack_i = 1'b0, wb_err_i = 1'b0, wb_rty_i = 1'b0;
    logic [31:0] wb_dat_i = '0;

    // target model configuration (driven by the stimulus process)
    logic [95:0] pat = PAT;
    bit          hold_ack = 1'b0;
    int          noack_read = -1;
    int          rty_read = -1;
    int          rty_num = 0;
    int          err_read = -1;

    // target model state
    int          rd_idx = 0;
    int          rty_given = 0;
    int          txn = 0;
    bit          responded = 1'b0;
    bit          extra = 1'b0;
    bit          attr_bad = 1'b0;
    logic [3:0]  wr_sel = '0;
    logic [31:0] wr_dat = '0;

    typedef struct {
        logic [95:0] dna;
        int          lat;
        bit          err;
    } exp_t;
    exp_t sbq[$];

    int n_vec = 0;
    int n_err = 0;

    surf_dna_reader dut (
        .wb_clk_i(clk),
        .wb_rst_i(rst),
        .start_i (start_i),
        .busy_o  (busy_o),
        .valid_o (valid_o),
        .error_o (error_o),
        .dna_o   (dna_o),
        .wb_cyc_o(wb_cyc_o),
        .wb_stb_o(wb_stb_o),
        .wb_we_o (wb_we_o),
        .wb_adr_o(wb_adr_o),
        .wb_dat_o(wb_dat_o),
        .wb_sel_o(wb_sel_o),
        .wb_ack_i(wb_ack_i),
        .wb_err_i(wb_err_i),
        .wb_rty_i(wb_rty_i),
        .wb_dat_i(wb_dat_i)
    );

    always #5 clk = ~clk;

    // Registered target: responds one cycle after it sees a new strobe
    always @(posedge clk) begin
        wb_ack_i <= 1'b0;
        wb_rty_i <= 1'b0;
        wb_err_i <= 1'b0;
        if (rst) begin
            responded <= 1'b0;
            extra     <= 1'b0;
        end else begin
            if (extra) begin
                wb_ack_i <= 1'b1;
                extra    <= 1'b0;
            end
            if (wb_cyc_o && wb_stb_o && !responded) begin
                responded <= 1'b1;
                if (wb_adr_o != 11'h008) attr_bad <= 1'b1;
                if (wb_we_o) begin
                    wb_ack_i  <= 1'b1;
                    wr_sel    <= wb_sel_o;
                    wr_dat    <= wb_dat_o;
                    rd_idx    <= 0;
                    rty_given <= 0;
                    txn       <= txn + 1;
                end else begin
                    if (wb_sel_o != 4'hF || wb_dat_o != 32'h0) attr_bad <= 1'b1;
                    if (rd_idx == err_read) begin
                        wb_err_i <= 1'b1;
                    end else if (rd_idx != noack_read) begin
                        if (rd_idx == rty_read && rty_given < rty_num) begin
                            wb_rty_i  <= 1'b1;
                            rty_given <= rty_given + 1;
                        end else begin
                            wb_ack_i <= 1'b1;
                            wb_dat_i <= {31'b0, pat[rd_idx]};
                            rd_idx   <= rd_idx + 1;
                            txn      <= txn + 1;
                            extra    <= hold_ack;
                        end
                    end
                end
            end else if (!wb_cyc_o) begin
                responded <= 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One readout: push expectation on start, pop and compare on valid/error
    task automatic run_rd(input logic [95:0] exp_dna, input int lat, input bit err,
                          input int poke, output int n_end, output int n_rise);
        exp_t e;
        int   t0;
        logic pstb;
        sbq.push_back('{exp_dna, lat, err});
        t0      = txn;
        pstb    = 1'b0;
        n_rise  = 0;
        n_end   = 0;
        start_i = 1'b1;
        for (int n = 1; n <= 2000; n++) begin
            @(posedge clk); #1;
            start_i = (n == poke);
            if (n == 1) begin
                chk("busy_on_start", busy_o, 1);
                chk("valid_clr", valid_o, 0);
                chk("error_clr", error_o, 0);
            end
            if (wb_stb_o && !pstb) n_rise = n;
            pstb = wb_stb_o;
            if (valid_o || error_o) begin
                n_end = n;
                break;
            end
        end
        start_i = 1'b0;
        if (n_end == 0) chk("done_wait", valid_o | error_o, 1);
        e = sbq.pop_front();
        chk("valid", valid_o, !e.err);
        chk("error", error_o, e.err);
        chk("busy_end", busy_o, 0);
        if (!e.err) begin
            chk("dna", dna_o, e.dna);
            chk("latency", n_end, e.lat);
            chk("txn_cnt", txn - t0, 97);
        end else begin
            chk("cyc_on_err", wb_cyc_o, 0);
        end
    endtask

    initial begin
        int ne, nr;
        bit found;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cyc", wb_cyc_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_valid", valid_o, 0);
        chk("rst_error", error_o, 0);
        chk("rst_dna", dna_o, 0);
        chk("rst_sel", wb_sel_o, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // plain readout
        run_rd(PAT, 390, 0, -1, ne, nr);
        chk("wr_sel", wr_sel, 4'b1000);
        chk("wr_dat", wr_dat, 32'h8000_0000);

        // target holds ack an extra cycle
        hold_ack = 1'b1;
        run_rd(PAT, 390, 0, -1, ne, nr);
        hold_ack = 1'b0;

        // two retries on read 10, then four
        rty_read = 10;
        rty_num  = 2;
        run_rd(PAT, 398, 0, -1, ne, nr);
        rty_num  = 4;
        run_rd(PAT, 0, 1, -1, ne, nr);
        rty_read = -1;

        // error response on read 5
        err_read = 5;
        run_rd(PAT, 0, 1, -1, ne, nr);
        err_read = -1;

        // no response on read 50
        noack_read = 50;
        run_rd(PAT, 0, 1, -1, ne, nr);
        chk("timeout_cycles", ne - nr, 255);
        noack_read = -1;

        // reset in the middle of read 40
        found   = 1'b0;
        start_i = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            @(posedge clk); #1;
            start_i = 1'b0;
            if (rd_idx == 40 && wb_cyc_o) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) chk("rd40_wait", wb_cyc_o, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mrst_cyc", wb_cyc_o, 0);
        chk("mrst_we", wb_we_o, 0);
        chk("mrst_sel", wb_sel_o, 0);
        chk("mrst_busy", busy_o, 0);
        chk("mrst_valid", valid_o, 0);
        chk("mrst_error", error_o, 0);
        chk("mrst_dna", dna_o, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        run_rd(PAT, 390, 0, -1, ne, nr);

        // start while busy is ignored, start in DONE reruns
        pat = PAT2;
        run_rd(PAT2, 390, 0, 100, ne, nr);
        pat = PAT;
        run_rd(PAT, 390, 0, -1, ne, nr);

        chk("bus_attr", attr_bad, 0);
        chk("sb_empty", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
